// File: rtl/line_follow_seq.sv
// Top-level sequencer for the line-following PID datapath: command handling,
// IR sample qualification/decimation, and line-loss timeout with a sticky flag.
module line_follow_seq #(
    parameter int unsigned DECIM    = 1,
    parameter logic [23:0] LOST_TMO = 24'd1_000_000,
    parameter bit          FAST_SIM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_rdy,
    input  logic [1:0] cmd,
    output logic       clr_cmd_rdy,
    input  logic       ir_rdy,
    input  logic       line_present,
    output logic       go,
    output logic       err_vld,
    output logic       lost,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        GAP  = 2'b10,
        LOST = 2'b11
    } state_t;

    localparam logic [1:0]  CMD_START = 2'b01;
    localparam logic [1:0]  CMD_STOP  = 2'b10;
    localparam logic [23:0] TMO       = FAST_SIM ? (LOST_TMO >> 10) : LOST_TMO;
    localparam logic [23:0] GAP_LAST  = TMO - 24'd1;
    localparam logic [3:0]  DEC_LAST  = 4'(DECIM - 1);
    localparam logic [23:0] GAP_MAX   = 24'hFF_FFFF;

    state_t      state_reg;
    logic [23:0] gap_cnt_reg;
    logic [3:0]  dec_cnt_reg;
    logic        clr_cmd_rdy_reg;
    logic        cmd_held_reg;
    logic        go_reg;
    logic        err_vld_reg;
    logic        lost_reg;

    logic cmd_accept;
    logic is_start;
    logic is_stop;

    // A level-held cmd_rdy is taken once; it must drop before the next command.
    assign cmd_accept = cmd_rdy && !clr_cmd_rdy_reg && !cmd_held_reg;
    assign is_start   = cmd_accept && (cmd == CMD_START);
    assign is_stop    = cmd_accept && (cmd == CMD_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            gap_cnt_reg     <= '0;
            dec_cnt_reg     <= '0;
            clr_cmd_rdy_reg <= 1'b0;
            cmd_held_reg    <= 1'b0;
            go_reg          <= 1'b0;
            err_vld_reg     <= 1'b0;
            lost_reg        <= 1'b0;
        end else begin
            clr_cmd_rdy_reg <= cmd_accept;
            cmd_held_reg    <= cmd_rdy && (cmd_held_reg || cmd_accept);
            err_vld_reg     <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (is_start) begin
                        state_reg   <= RUN;
                        go_reg      <= 1'b1;
                        lost_reg    <= 1'b0;
                        dec_cnt_reg <= '0;
                    end
                end

                RUN: begin
                    if (is_stop) begin
                        state_reg <= IDLE;
                        go_reg    <= 1'b0;
                    end else if (!line_present) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                    end else if (ir_rdy) begin
                        if (dec_cnt_reg == DEC_LAST) begin
                            dec_cnt_reg <= '0;
                            err_vld_reg <= 1'b1;
                        end else begin
                            dec_cnt_reg <= dec_cnt_reg + 4'd1;
                        end
                    end
                end

                GAP: begin
                    // Stop beats timeout, timeout beats line reacquisition.
                    if (is_stop) begin
                        state_reg <= IDLE;
                        go_reg    <= 1'b0;
                    end else if (gap_cnt_reg >= GAP_LAST) begin
                        state_reg <= LOST;
                        go_reg    <= 1'b0;
                        lost_reg  <= 1'b1;
                    end else if (line_present) begin
                        state_reg   <= RUN;
                        dec_cnt_reg <= '0;
                    end else if (gap_cnt_reg != GAP_MAX) begin
                        gap_cnt_reg <= gap_cnt_reg + 24'd1;
                    end
                end

                LOST: begin
                    if (is_start) begin
                        state_reg   <= RUN;
                        go_reg      <= 1'b1;
                        lost_reg    <= 1'b0;
                        dec_cnt_reg <= '0;
                    end else if (is_stop) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    go_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign clr_cmd_rdy = clr_cmd_rdy_reg;
    assign go          = go_reg;
    assign err_vld     = err_vld_reg;
    assign lost        = lost_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_line_follow_seq.sv
// Directed bench for line_follow_seq: ack and err_vld timing are checked
// against cycle-stamped expectation queues by a negedge monitor.
module tb_line_follow_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_rdy;
    logic [1:0] cmd;
    logic       clr_cmd_rdy;
    logic       ir_rdy;
    logic       line_present;
    logic       go;
    logic       err_vld;
    logic       lost;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_err_q[$];
    int exp_ack_q[$];

    line_follow_seq #(
        .DECIM   (3),
        .LOST_TMO(24'd1_000_000),
        .FAST_SIM(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .ir_rdy      (ir_rdy),
        .line_present(line_present),
        .go          (go),
        .err_vld     (err_vld),
        .lost        (lost),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every err_vld / clr_cmd_rdy pulse must match a queued cycle.
    always @(negedge clk) begin
        if (exp_err_q.size() != 0 && exp_err_q[0] == cyc) begin
            void'(exp_err_q.pop_front());
            chk("err_vld_pulse", {31'd0, err_vld}, 32'd1);
            $display("txn err_vld cycle=%0d", cyc);
        end else if (err_vld !== 1'b0) begin
            checks++;
            failures++;
            $error("FAIL err_vld_spurious observed=%b expected=0 cycle=%0d", err_vld, cyc);
        end
        if (exp_ack_q.size() != 0 && exp_ack_q[0] == cyc) begin
            void'(exp_ack_q.pop_front());
            chk("clr_cmd_rdy_pulse", {31'd0, clr_cmd_rdy}, 32'd1);
            $display("txn ack cycle=%0d", cyc);
        end else if (clr_cmd_rdy !== 1'b0) begin
            checks++;
            failures++;
            $error("FAIL clr_cmd_rdy_spurious observed=%b expected=0 cycle=%0d", clr_cmd_rdy, cyc);
        end
    end

    task automatic issue_cmd(input logic [1:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        exp_ack_q.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic release_cmd();
        cmd_rdy = 1'b0;
        cmd     = 2'b00;
    endtask

    task automatic pulse_ir(input int gap_cycles, input bool_expect);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ir_count;
        int gap_start;
        int lost_cyc;
        logic found;
        logic go_dropped;

        rst_n = 1'b0; cmd_rdy = 1'b0; cmd = 2'b00; ir_rdy = 1'b0; line_present = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {30'd0, state}, 32'd0);
        chk("reset_go", {31'd0, go}, 32'd0);
        chk("reset_lost", {31'd0, lost}, 32'd0);
        chk("reset_err_vld", {31'd0, err_vld}, 32'd0);
        chk("reset_clr_cmd_rdy", {31'd0, clr_cmd_rdy}, 32'd0);
        rst_n = 1'b1;
        line_present = 1'b1;
        @(negedge clk);

        // 1: START, held cmd_rdy must not be acknowledged twice
        issue_cmd(2'b01);
        chk("start_clr", {31'd0, clr_cmd_rdy}, 32'd1);
        chk("start_state", {30'd0, state}, 32'd1);
        chk("start_go", {31'd0, go}, 32'd1);
        repeat (3) @(negedge clk);
        chk("held_no_reack", {31'd0, clr_cmd_rdy}, 32'd0);
        release_cmd();
        @(negedge clk);

        // 2: decimation by 3
        ir_count = 0;
        for (int k = 0; k < 9; k++) begin
            ir_rdy = 1'b1;
            ir_count++;
            if (ir_count % 3 == 0) exp_err_q.push_back(cyc + 1);
            @(negedge clk);
            ir_rdy = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("decim_state", {30'd0, state}, 32'd1);

        // 3: short gap, ir_rdy ignored
        line_present = 1'b0;
        @(negedge clk);
        chk("gap_enter_state", {30'd0, state}, 32'd2);
        go_dropped = 1'b0;
        for (int k = 1; k < 500; k++) begin
            ir_rdy = (k % 50 == 0);
            @(negedge clk);
            if (go !== 1'b1) go_dropped = 1'b1;
        end
        ir_rdy = 1'b0;
        chk("gap_go_held", {31'd0, go_dropped}, 32'd0);
        line_present = 1'b1;
        @(negedge clk);
        chk("gap_exit_state", {30'd0, state}, 32'd1);
        chk("gap_exit_lost", {31'd0, lost}, 32'd0);
        chk("gap_exit_go", {31'd0, go}, 32'd1);

        // 4: line loss after TMO = 976 cycles in GAP
        line_present = 1'b0;
        gap_start = cyc + 1;
        found = 1'b0;
        lost_cyc = 0;
        for (int i = 0; i < 1100 && !found; i++) begin
            @(negedge clk);
            if (state === 2'b11) begin
                found = 1'b1;
                lost_cyc = cyc;
            end
        end
        chk("lost_reached", {31'd0, found}, 32'd1);
        chk("lost_latency", lost_cyc - gap_start, 32'd976);
        chk("lost_flag", {31'd0, lost}, 32'd1);
        chk("lost_go", {31'd0, go}, 32'd0);
        repeat (24) @(negedge clk);
        chk("lost_sticky_state", {30'd0, state}, 32'd3);
        line_present = 1'b1;
        issue_cmd(2'b01);
        release_cmd();
        chk("restart_state", {30'd0, state}, 32'd1);
        chk("restart_lost", {31'd0, lost}, 32'd0);

        // 5a: STOP on the timeout edge wins
        line_present = 1'b0;
        repeat (976) @(negedge clk);
        chk("pre_stop_state", {30'd0, state}, 32'd2);
        issue_cmd(2'b10);
        release_cmd();
        chk("stop_vs_tmo_state", {30'd0, state}, 32'd0);
        chk("stop_vs_tmo_lost", {31'd0, lost}, 32'd0);
        chk("stop_vs_tmo_go", {31'd0, go}, 32'd0);

        // 5b: STOP in RUN
        line_present = 1'b1;
        @(negedge clk);
        issue_cmd(2'b01);
        release_cmd();
        @(negedge clk);
        chk("run_go", {31'd0, go}, 32'd1);
        issue_cmd(2'b10);
        release_cmd();
        chk("run_stop_go", {31'd0, go}, 32'd0);
        chk("run_stop_state", {30'd0, state}, 32'd0);
        @(negedge clk);

        // 6: asynchronous reset mid-run with a pending command
        issue_cmd(2'b01);
        release_cmd();
        @(negedge clk);
        ir_rdy = 1'b1;
        @(negedge clk);
        ir_rdy = 1'b0;
        cmd = 2'b01;
        cmd_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {30'd0, state}, 32'd0);
        chk("mid_rst_go", {31'd0, go}, 32'd0);
        chk("mid_rst_lost", {31'd0, lost}, 32'd0);
        chk("mid_rst_err_vld", {31'd0, err_vld}, 32'd0);
        chk("mid_rst_clr", {31'd0, clr_cmd_rdy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ack_q.push_back(cyc + 1);
        @(negedge clk);
        release_cmd();
        chk("post_rst_ack", {31'd0, clr_cmd_rdy}, 32'd1);
        chk("post_rst_state", {30'd0, state}, 32'd1);
        ir_count = 0;
        for (int k = 0; k < 3; k++) begin
            ir_rdy = 1'b1;
            ir_count++;
            if (ir_count % 3 == 0) exp_err_q.push_back(cyc + 1);
            @(negedge clk);
            ir_rdy = 1'b0;
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("err_queue_drained", exp_err_q.size(), 32'd0);
        chk("ack_queue_drained", exp_ack_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
